// File: rtl/ps2_keypress_filter_if.sv
// Byte-stream input and make-code FIFO output bundle of ps2_keypress_filter.
interface ps2_keypress_filter_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       i_ready;
  logic [7:0] o_key_code;
  logic       o_extended;
  logic       o_valid;
  logic       o_overflow;
  logic       o_key_held;

  modport master (
    output received_data, received_data_en, i_ready,
    input  o_key_code, o_extended, o_valid, o_overflow, o_key_held
  );

  modport slave (
    input  received_data, received_data_en, i_ready,
    output o_key_code, o_extended, o_valid, o_overflow, o_key_held
  );
endinterface

// File: rtl/ps2_keypress_filter.sv
// Reduces the raw PS/2 byte stream to one make code per key press and
// queues those codes in a small valid/ready FIFO.
module ps2_keypress_filter #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
  parameter bit          PASS_EXTENDED  = 1'b0
) (
  input logic                  CLOCK_50,
  input logic                  reset_n,
  ps2_keypress_filter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(PREFIX_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic [1:0]       state, state_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [7:0]       held_code, held_n;
  logic             key_held_n;
  logic             push_req, push_ext;
  logic [7:0]       b;
  logic             is_status;

  logic [7:0]       mem_code [FIFO_DEPTH];
  logic             mem_ext  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CNT_W-1:0] count, count_n;
  logic             pop, full, push_ok, overflow_set;
  logic [7:0]       head_code_n;
  logic             head_ext_n;

  assign b         = bus.received_data;
  assign is_status = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
                     (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);

  // Byte classification, held-key tracking and prefix timeout
  always_comb begin
    state_n    = state;
    tmo_n      = tmo_cnt;
    held_n     = held_code;
    key_held_n = bus.o_key_held;
    push_req   = 1'b0;
    push_ext   = 1'b0;
    if (bus.received_data_en) begin
      tmo_n = '0;
      case (state)
        ST_IDLE: begin
          if (b == 8'hE0) begin
            state_n = ST_EXT;
          end else if (b == 8'hF0) begin
            state_n = ST_BRK;
          end else if (!is_status && !(bus.o_key_held && b == held_code)) begin
            push_req   = 1'b1;
            held_n     = b;
            key_held_n = 1'b1;
          end
        end
        ST_EXT: begin
          if (b == 8'hF0) begin
            state_n = ST_EXT_BRK;
          end else if (b != 8'hE0) begin
            push_req = PASS_EXTENDED;
            push_ext = 1'b1;
            state_n  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (bus.o_key_held && b == held_code) key_held_n = 1'b0;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_W'(PREFIX_TIMEOUT - 1)) begin
        state_n = ST_IDLE;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo_cnt + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      tmo_cnt        <= '0;
      held_code      <= 8'h00;
      bus.o_key_held <= 1'b0;
    end else begin
      state          <= state_n;
      tmo_cnt        <= tmo_n;
      held_code      <= held_n;
      bus.o_key_held <= key_held_n;
    end
  end

  // FIFO control; a push into an empty (or just-emptied) FIFO bypasses to the head
  assign pop          = bus.o_valid && bus.i_ready;
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok      = push_req && (!full || pop);
  assign overflow_set = push_req && full && !pop;
  assign rd_n         = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_comb begin
    count_n = count;
    case ({push_ok, pop})
      2'b10:   count_n = count + CNT_W'(1);
      2'b01:   count_n = count - CNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    head_code_n = mem_code[rd_n];
    head_ext_n  = mem_ext[rd_n];
    if (push_ok && wr_ptr == rd_n) begin
      head_code_n = b;
      head_ext_n  = push_ext;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem_code[wr_ptr] <= b;
      mem_ext[wr_ptr]  <= push_ext;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_key_code <= 8'h00;
      bus.o_extended <= 1'b0;
      bus.o_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_n;
      count       <= count_n;
      bus.o_valid <= (count_n != '0);
      if (count_n != '0) begin
        bus.o_key_code <= head_code_n;
        bus.o_extended <= head_ext_n;
      end
      if (overflow_set) bus.o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keypress_filter.sv
// Bench for ps2_keypress_filter: one instance drops extended makes, the other
// forwards them; both see the same byte stream and have separate scoreboards.
module tb_ps2_keypress_filter;

  localparam int unsigned PT = 16;

  typedef struct {
    logic [7:0] code;
    logic       ext;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    bit         push0;
    bit         push1;
    bit         ext;
    bit         held;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miss_cnt;
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[$];

  ps2_keypress_filter_if if0 ();
  ps2_keypress_filter_if if1 ();

  assign if1.received_data    = if0.received_data;
  assign if1.received_data_en = if0.received_data_en;
  assign if1.i_ready          = if0.i_ready;

  ps2_keypress_filter #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(PT), .PASS_EXTENDED(1'b0)) dut0 (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (if0.slave)
  );

  ps2_keypress_filter #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(PT), .PASS_EXTENDED(1'b1)) dut1 (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every accepted head entry is checked against its scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if0.o_valid && if0.i_ready) begin
      vec_cnt++;
      if (q0.size() == 0) begin
        miss_cnt++;
        $display("FAIL dut0_out: got code %h ext %b expected no output", if0.o_key_code, if0.o_extended);
      end else begin
        e = q0.pop_front();
        if (if0.o_key_code !== e.code || if0.o_extended !== e.ext) begin
          miss_cnt++;
          $display("FAIL dut0_out: got %h/%b expected %h/%b", if0.o_key_code, if0.o_extended, e.code, e.ext);
        end
      end
    end
    if (rst_n && if1.o_valid && if1.i_ready) begin
      vec_cnt++;
      if (q1.size() == 0) begin
        miss_cnt++;
        $display("FAIL dut1_out: got code %h ext %b expected no output", if1.o_key_code, if1.o_extended);
      end else begin
        e = q1.pop_front();
        if (if1.o_key_code !== e.code || if1.o_extended !== e.ext) begin
          miss_cnt++;
          $display("FAIL dut1_out: got %h/%b expected %h/%b", if1.o_key_code, if1.o_extended, e.code, e.ext);
        end
      end
    end
  end

  task automatic send(input logic [7:0] bt, input bit p0, input bit p1, input bit ext);
    exp_t e;
    e.code = bt;
    e.ext  = ext;
    @(posedge clk); #1;
    if0.received_data    = bt;
    if0.received_data_en = 1'b1;
    if (p0) q0.push_back(e);
    if (p1) q1.push_back(e);
    @(posedge clk); #1;
    if0.received_data_en = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input bit p0, input bit p1, input bit ext, input bit held);
    vec_t v;
    v.data = d; v.push0 = p0; v.push1 = p1; v.ext = ext; v.held = held;
    tbl.push_back(v);
  endtask

  task automatic chk_held(input string name, input bit exp);
    @(negedge clk);
    chk({name, "_held0"}, 8'(if0.o_key_held), 8'(exp));
    chk({name, "_held1"}, 8'(if1.o_key_held), 8'(exp));
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    rst_n    = 1'b0;
    if0.received_data    = 8'h00;
    if0.received_data_en = 1'b0;
    if0.i_ready          = 1'b1;

    // press / release
    add(8'h1C, 1, 1, 0, 1); add(8'hF0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 0);
    // typematic repeat then re-press
    add(8'h1C, 1, 1, 0, 1); add(8'h1C, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 1);
    add(8'hF0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 0); add(8'h1C, 1, 1, 0, 1);
    add(8'hF0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 0);
    // roll-over
    add(8'h1C, 1, 1, 0, 1); add(8'h32, 1, 1, 0, 1); add(8'hF0, 0, 0, 0, 1);
    add(8'h1C, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 1); add(8'h32, 0, 0, 0, 0);
    // extended make / break
    add(8'hE0, 0, 0, 0, 0); add(8'h75, 0, 1, 1, 0); add(8'hE0, 0, 0, 0, 0);
    add(8'hF0, 0, 0, 0, 0); add(8'h75, 0, 0, 0, 0);
    // status bytes
    add(8'hAA, 0, 0, 0, 0); add(8'hFA, 0, 0, 0, 0); add(8'h00, 0, 0, 0, 0);
    add(8'hFF, 0, 0, 0, 0); add(8'hEE, 0, 0, 0, 0); add(8'hFE, 0, 0, 0, 0);
    // repeated E0 prefix
    add(8'hE0, 0, 0, 0, 0); add(8'hE0, 0, 0, 0, 0); add(8'h75, 0, 1, 1, 0);
    // extended make while a normal key is held
    add(8'h1C, 1, 1, 0, 1); add(8'hE0, 0, 0, 0, 1); add(8'h1C, 0, 1, 1, 1);
    add(8'h1C, 0, 0, 0, 1); add(8'hF0, 0, 0, 0, 1); add(8'h1C, 0, 0, 0, 0);

    #12;
    chk("rst_valid0", 8'(if0.o_valid), 8'h00);
    chk("rst_code0", if0.o_key_code, 8'h00);
    chk("rst_ext1", 8'(if1.o_extended), 8'h00);
    chk("rst_ovf0", 8'(if0.o_overflow), 8'h00);
    chk("rst_held1", 8'(if1.o_key_held), 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i].data, tbl[i].push0, tbl[i].push1, tbl[i].ext);
      repeat (2) @(posedge clk);
      chk_held($sformatf("vec%0d", i), tbl[i].held);
    end
    repeat (3) @(posedge clk);
    chk("tbl_q0_drained", 8'(q0.size()), 8'h00);
    chk("tbl_q1_drained", 8'(q1.size()), 8'h00);

    // overflow with downstream stalled
    if0.i_ready = 1'b0;
    send(8'h15, 1, 1, 0); send(8'hF0, 0, 0, 0); send(8'h15, 0, 0, 0);
    send(8'h1D, 1, 1, 0); send(8'hF0, 0, 0, 0); send(8'h1D, 0, 0, 0);
    send(8'h24, 1, 1, 0); send(8'hF0, 0, 0, 0); send(8'h24, 0, 0, 0);
    send(8'h2D, 1, 1, 0); send(8'hF0, 0, 0, 0); send(8'h2D, 0, 0, 0);
    @(negedge clk);
    chk("ovf_before", 8'(if0.o_overflow), 8'h00);
    send(8'h2C, 0, 0, 0);
    @(negedge clk);
    chk("ovf_set0", 8'(if0.o_overflow), 8'h01);
    chk("ovf_set1", 8'(if1.o_overflow), 8'h01);
    chk("ovf_head_stable", if0.o_key_code, 8'h15);
    chk("ovf_held", 8'(if0.o_key_held), 8'h01);
    if0.i_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("ovf_empty0", 8'(if0.o_valid), 8'h00);
    chk("ovf_q0_drained", 8'(q0.size()), 8'h00);
    chk("ovf_sticky", 8'(if0.o_overflow), 8'h01);
    send(8'hF0, 0, 0, 0); send(8'h2C, 0, 0, 0);
    chk_held("ovf_release", 1'b0);

    // extended make one cycle before the prefix timeout expires
    send(8'hE0, 0, 0, 0);
    repeat (PT - 3) @(posedge clk);
    send(8'h75, 0, 1, 1);
    repeat (3) @(posedge clk);
    chk_held("tmo_edge", 1'b0);

    // prefix timeout aborts E0, so 1C is a normal make
    send(8'hE0, 0, 0, 0);
    repeat (PT + 2) @(posedge clk);
    send(8'h1C, 1, 1, 0);
    repeat (2) @(posedge clk);
    chk_held("tmo_make", 1'b1);
    send(8'hF0, 0, 0, 0); send(8'h1C, 0, 0, 0);
    chk_held("tmo_release", 1'b0);
    chk("tmo_q1_drained", 8'(q1.size()), 8'h00);

    // asynchronous reset with entries queued
    if0.i_ready = 1'b0;
    send(8'h1C, 1, 1, 0); send(8'hF0, 0, 0, 0); send(8'h1C, 0, 0, 0);
    send(8'h32, 1, 1, 0);
    @(negedge clk);
    chk("pre_rst_valid", 8'(if0.o_valid), 8'h01);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid0", 8'(if0.o_valid), 8'h00);
    chk("arst_valid1", 8'(if1.o_valid), 8'h00);
    chk("arst_ovf0", 8'(if0.o_overflow), 8'h00);
    chk("arst_code", if0.o_key_code, 8'h00);
    chk("arst_held", 8'(if1.o_key_held), 8'h00);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    if0.i_ready = 1'b1;
    send(8'h32, 1, 1, 0);
    repeat (3) @(posedge clk);
    chk_held("post_rst", 1'b1);
    chk("end_q0", 8'(q0.size()), 8'h00);
    chk("end_q1", 8'(q1.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
